// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port memory between instruction fetch and the
//            data stage. Data wins by default; fetch is forced after
//            STARVE_LIMIT consecutive data wins over a waiting fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // instruction fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  // data memory port
  input  logic                dm_read,
  input  logic                dm_write,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                dm_stall,
  // memory side
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          owner
);

  localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t     r_state;
  logic [3:0] r_starve_cnt;
  logic       w_dm_req;
  logic       w_pick_if;

  assign w_dm_req  = dm_read | dm_write;
  // Fetch wins only when alone, or when it has been passed over too often.
  assign w_pick_if = if_req & (~w_dm_req | (r_starve_cnt == c_limit));

  assign if_stall  = if_req & ~if_valid;
  assign dm_stall  = w_dm_req & ~dm_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= 4'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
      if_valid     <= 1'b0;
      dm_valid     <= 1'b0;
      owner        <= 2'b00;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_if) begin
            r_state      <= BUSY_I;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= if_addr;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            owner        <= 2'b01;
            r_starve_cnt <= 4'd0;
          end else if (w_dm_req) begin
            // A simultaneous read+write is performed as a store.
            r_state   <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_write;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_write ? dm_wstrb : '0;
            owner     <= 2'b10;
            if (if_req && (r_starve_cnt != c_limit)) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            owner    <= 2'b00;
            r_state  <= RESP_I;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
            dm_valid <= 1'b1;
            owner    <= 2'b00;
            r_state  <= RESP_D;
          end
        end
        RESP_I:  r_state <= IDLE;
        RESP_D:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Randomized self-checking bench with a transaction-level model of
//            the arbiter, a memory agent and two requester agents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid, if_stall;
  logic              dm_read = 1'b0, dm_write = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic [STRB_W-1:0] dm_wstrb = '0;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid, dm_stall;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [1:0]        owner;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata),
    .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: phase of the shared port as seen from outside.
  localparam int PH_FREE = 0, PH_BUSY = 1, PH_RESP = 2;
  logic [31:0] mem_m [128];
  int          ph = PH_FREE;
  int          starve = 0;
  logic [1:0]  e_owner = 2'b00;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic        e_we = 1'b0;
  logic [3:0]  e_wstrb = '0;
  logic [31:0] e_if_rd = '0, e_dm_rd = '0;
  int          ack_dly = 0, fix_dly = -1;
  bit          hold_ack = 0, spur_en = 1, if_en = 1, dm_en = 1;
  int          if_gap = 0, dm_gap = 0, if_gap_max = 3, dm_gap_max = 3;
  int          if_wait = 0, dm_wait = 0, n_fetch_grants = 0;

  task automatic step();
    bit ivld, dvld, dwin;
    int r;
    @(negedge clk);
    // advance the model by one cycle using what the DUT saw at the last edge
    case (ph)
      PH_FREE: if (if_req || dm_read || dm_write) begin
        dwin = (dm_read || dm_write) && !(if_req && starve == LIMIT);
        if (dwin) begin
          e_owner = 2'b10; e_addr = dm_addr; e_we = dm_write; e_wdata = dm_wdata;
          e_wstrb = dm_write ? dm_wstrb : 4'h0;
          if (if_req && starve < LIMIT) starve++;
        end else begin
          e_owner = 2'b01; e_addr = if_addr; e_we = 1'b0; e_wstrb = 4'h0;
          starve = 0;
          n_fetch_grants++;
        end
        ack_dly = (fix_dly >= 0) ? fix_dly : $urandom_range(0, 5);
        ph = PH_BUSY;
      end
      PH_BUSY: if (mem_ack) ph = PH_RESP;
      default: ph = PH_FREE;
    endcase

    ivld = (ph == PH_RESP) && (e_owner == 2'b01);
    dvld = (ph == PH_RESP) && (e_owner == 2'b10);
    check("mem_req", 32'(mem_req), 32'(ph == PH_BUSY));
    check("owner", 32'(owner), (ph == PH_BUSY) ? 32'(e_owner) : 32'd0);
    if (ph == PH_BUSY) begin
      check("mem_addr", mem_addr, e_addr);
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
      if (e_we) check("mem_wdata", mem_wdata, e_wdata);
    end
    check("if_valid", 32'(if_valid), 32'(ivld));
    check("dm_valid", 32'(dm_valid), 32'(dvld));
    check("if_rdata", if_rdata, e_if_rd);
    check("dm_rdata", dm_rdata, e_dm_rd);
    check("if_stall", 32'(if_stall), 32'(if_req && !ivld));
    check("dm_stall", 32'(dm_stall), 32'((dm_read || dm_write) && !dvld));

    // memory agent
    mem_ack = 1'b0;
    if (ph == PH_BUSY) begin
      if (!(hold_ack && e_owner == 2'b10) && ack_dly == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_m[mem_addr[8:2]];
        if (e_owner == 2'b01) e_if_rd = mem_m[e_addr[8:2]];
        else if (!e_we)       e_dm_rd = mem_m[e_addr[8:2]];
        if (mem_we) begin
          for (int b = 0; b < STRB_W; b++)
            if (mem_wstrb[b]) mem_m[mem_addr[8:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
      end else if (ack_dly > 0) begin
        ack_dly--;
      end
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
    end

    // fetch requester
    if (ivld) begin
      if_req = 1'b0;
      if_gap = $urandom_range(0, if_gap_max);
    end else if (!if_req) begin
      if (if_gap > 0) if_gap--;
      else if (if_en) begin
        if_req  = 1'b1;
        if_addr = 32'($urandom_range(0, 127)) << 2;
      end
    end

    // data requester
    if (dvld) begin
      dm_read = 1'b0; dm_write = 1'b0;
      dm_gap  = $urandom_range(0, dm_gap_max);
    end else if (!(dm_read || dm_write)) begin
      if (dm_gap > 0) dm_gap--;
      else if (dm_en) begin
        r = $urandom_range(0, 7);
        dm_read  = (r < 4);
        dm_write = (r == 0) || (r >= 4);
        dm_addr  = 32'($urandom_range(0, 127)) << 2;
        dm_wdata = $urandom;
        dm_wstrb = 4'($urandom_range(1, 15));
      end
    end

    if_wait = if_req ? if_wait + 1 : 0;
    dm_wait = (dm_read || dm_write) ? dm_wait + 1 : 0;
    if (if_wait == 60) check("if_wait_cycles", 32'(if_wait), 32'd0);
    if (dm_wait == 60) check("dm_wait_cycles", 32'(dm_wait), 32'd0);
  endtask

  task automatic drain();
    if_en = 0; dm_en = 0;
    for (int i = 0; i < 100; i++) begin
      if (ph == PH_FREE && !if_req && !dm_read && !dm_write) break;
      step();
    end
    check("drain_idle", 32'(ph == PH_FREE && !if_req && !dm_read && !dm_write), 32'd1);
  endtask

  initial begin
    bit found;
    int fg0;
    for (int i = 0; i < 128; i++) mem_m[i] = $urandom;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_valids", 32'({if_valid, dm_valid}), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if_en = 0; dm_en = 0; spur_en = 0;

    // fetch only, minimum latency
    mem_m[64] = 32'h0050_0093;
    fix_dly = 0;
    if_req = 1'b1; if_addr = 32'h100;
    step(); step();
    check("fetch_rdata", if_rdata, 32'h0050_0093);
    drain();

    // store with 5-cycle ack delay
    fix_dly = 5;
    dm_write = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
    for (int i = 0; i < 12 && (dm_write || ph != PH_FREE); i++) step();
    check("store_mem", mem_m[0], 32'hDEAD_BEEF);
    drain();

    // simultaneous read+write at 0x40 is a store
    fix_dly = 1;
    dm_read = 1'b1; dm_write = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234_5678; dm_wstrb = 4'hF;
    for (int i = 0; i < 10 && (dm_write || ph != PH_FREE); i++) step();
    check("rw_store_mem", mem_m[16], 32'h1234_5678);
    drain();

    // heavy contention: both requesters re-request immediately
    fix_dly = -1; spur_en = 1;
    if_gap_max = 0; dm_gap_max = 0; if_en = 1; dm_en = 1;
    fg0 = n_fetch_grants;
    repeat (300) step();
    check("contention_fetch_served", 32'(n_fetch_grants > fg0), 32'd1);

    // general random traffic
    if_gap_max = 4; dm_gap_max = 3;
    repeat (2000) step();

    // reset while a data transaction is in flight
    hold_ack = 1; if_en = 0; found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (ph == PH_BUSY && e_owner == 2'b10) found = 1;
    end
    check("rst_busy_found", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    check("async_rst_dm_valid", 32'(dm_valid), 32'd0);
    check("async_rst_owner", 32'(owner), 32'd0);
    if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    check("rst_late_ack_valid", 32'({if_valid, dm_valid}), 32'd0);
    rst_n = 1'b1;
    ph = PH_FREE; starve = 0; e_if_rd = '0; e_dm_rd = '0;
    hold_ack = 0; if_gap = 0; dm_gap = 0;

    // spurious acks with no traffic, then resume traffic
    dm_en = 0;
    repeat (20) step();
    if_en = 1; dm_en = 1;
    repeat (500) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
